memory_bus_ram_slave: RTL

- Slave-side responder for the MemoryBus packet protocol, backed by an on-chip synchronous RAM.
- Accepts one master-to-slave (ms) request per cycle.
- Performs writes silently, with no response.
- Returns each read as a slave-to-master (sm) packet tagged with the requesting master's ID.
- Sits behind the bus arbiter as the scene/framebuffer word store for the ray-tracing units.
- Absorbs sm backpressure in a small response FIFO.

---
 rtl/memory_bus_ram_slave.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/memory_bus_ram_slave.sv
`default_nettype none
// ============================================================================
//  Module      : memory_bus_ram_slave
//  Description : MemoryBus slave backed by an on-chip synchronous RAM.
//                Writes are absorbed silently; each read returns one sm
//                packet tagged with the requester's ID, in acceptance order,
//                through a small credit-managed response FIFO.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   clock, all state on rising edge
//    rst_n      in   asynchronous active-low reset
//    msID       in   requesting master ID
//    msAddress  in   word address (low log2(DEPTH) bits used)
//    msData     in   write data
//    msWrite    in   1 = write, 0 = read
//    msValid    in   request valid
//    msReady    out  request can be accepted this cycle
//    smID       out  ID of the returned read
//    smData     out  read data
//    smValid    out  response valid
//    smReady    in   master accepts response
// ============================================================================
module memory_bus_ram_slave #(
  parameter int MASTER_ID_WIDTH = 8,
  parameter int ADDRESS_WIDTH   = 32,
  parameter int DATA_WIDTH      = 16,
  parameter int DEPTH           = 4096,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [MASTER_ID_WIDTH-1:0] msID,
  input  logic [ADDRESS_WIDTH-1:0]   msAddress,
  input  logic [DATA_WIDTH-1:0]      msData,
  input  logic                       msWrite,
  input  logic                       msValid,
  output logic                       msReady,
  output logic [MASTER_ID_WIDTH-1:0] smID,
  output logic [DATA_WIDTH-1:0]      smData,
  output logic                       smValid,
  input  logic                       smReady
);

  localparam int ADDR_BITS = $clog2(DEPTH);
  localparam int PTR_BITS  = $clog2(FIFO_DEPTH);
  localparam int CNT_W     = PTR_BITS + 1;
  // Occupancy = FIFO count plus up to two reads in the pipeline.
  localparam int OCC_W     = PTR_BITS + 2;

  // --------------------------------------------------------------------------
  // Storage
  // --------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0]      mem       [DEPTH];
  logic [DATA_WIDTH-1:0]      fifo_data [FIFO_DEPTH];
  logic [MASTER_ID_WIDTH-1:0] fifo_id   [FIFO_DEPTH];

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic                       ready_en_q,  ready_en_d;
  logic                       rd1_valid_q, rd1_valid_d;
  logic [ADDR_BITS-1:0]       rd1_addr_q,  rd1_addr_d;
  logic [MASTER_ID_WIDTH-1:0] rd1_id_q,    rd1_id_d;
  logic                       rd2_valid_q, rd2_valid_d;
  logic [MASTER_ID_WIDTH-1:0] rd2_id_q,    rd2_id_d;
  logic [DATA_WIDTH-1:0]      rd2_data_q;
  logic [PTR_BITS-1:0]        wr_ptr_q,    wr_ptr_d;
  logic [PTR_BITS-1:0]        rd_ptr_q,    rd_ptr_d;
  logic [CNT_W-1:0]           count_q,     count_d;

  logic                       w_ms_fire;
  logic                       w_rd_fire;
  logic                       w_wr_fire;
  logic                       w_push;
  logic                       w_pop;
  logic [ADDR_BITS-1:0]       w_index;
  logic [OCC_W-1:0]           w_occupancy;

  assign w_index   = msAddress[ADDR_BITS-1:0];
  assign w_ms_fire = msValid && msReady;
  assign w_rd_fire = w_ms_fire && !msWrite;
  assign w_wr_fire = w_ms_fire &&  msWrite;
  assign w_push    = rd2_valid_q;
  assign w_pop     = smValid && smReady;

  // Upper address bits are deliberately ignored so addresses alias.
  generate
    if (ADDRESS_WIDTH > ADDR_BITS) begin : g_unused_addr
      logic unused_addr_bits;
      assign unused_addr_bits = ^msAddress[ADDRESS_WIDTH-1:ADDR_BITS];
    end
  endgenerate

  // Credit is reserved at acceptance: every read in the pipeline already
  // owns a FIFO slot, so a push can never find the FIFO full.
  assign w_occupancy = OCC_W'(count_q) + OCC_W'(rd1_valid_q) + OCC_W'(rd2_valid_q);
  assign msReady     = ready_en_q && (w_occupancy < OCC_W'(FIFO_DEPTH));

  // Outputs are forced to zero while empty so reset presents clean values
  // even though the FIFO storage itself is not reset.
  assign smValid = (count_q != '0);
  assign smID    = smValid ? fifo_id[rd_ptr_q]   : '0;
  assign smData  = smValid ? fifo_data[rd_ptr_q] : '0;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    ready_en_d  = 1'b1;
    rd1_valid_d = w_rd_fire;
    rd1_addr_d  = rd1_addr_q;
    rd1_id_d    = rd1_id_q;
    rd2_valid_d = rd1_valid_q;
    rd2_id_d    = rd2_id_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q + CNT_W'(w_push) - CNT_W'(w_pop);

    if (w_rd_fire) begin
      rd1_addr_d = w_index;
      rd1_id_d   = msID;
    end
    if (rd1_valid_q) begin
      rd2_id_d = rd1_id_q;
    end
    if (w_push) begin
      wr_ptr_d = wr_ptr_q + PTR_BITS'(1);
    end
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_BITS'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Control registers (asynchronous reset)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en_q  <= 1'b0;
      rd1_valid_q <= 1'b0;
      rd1_addr_q  <= '0;
      rd1_id_q    <= '0;
      rd2_valid_q <= 1'b0;
      rd2_id_q    <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      ready_en_q  <= ready_en_d;
      rd1_valid_q <= rd1_valid_d;
      rd1_addr_q  <= rd1_addr_d;
      rd1_id_q    <= rd1_id_d;
      rd2_valid_q <= rd2_valid_d;
      rd2_id_q    <= rd2_id_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // --------------------------------------------------------------------------
  // RAM and FIFO storage (no reset). The RAM read happens one edge after
  // acceptance, so a write accepted the cycle before is already visible,
  // while a write accepted on the same edge as the RAM read is not.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_wr_fire) begin
      mem[w_index] <= msData;
    end
    if (rd1_valid_q) begin
      rd2_data_q <= mem[rd1_addr_q];
    end
    if (w_push) begin
      fifo_data[wr_ptr_q] <= rd2_data_q;
      fifo_id[wr_ptr_q]   <= rd2_id_q;
    end
  end

endmodule
`default_nettype wire
